// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, byte-enable
// patterns and the default access timeout.
package mem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_B1   = 4'b0010;
   localparam logic [3:0] BE_B2   = 4'b0100;
   localparam logic [3:0] BE_B3   = 4'b1000;

   localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_align.sv
// Lane steering for the data-memory port (purely combinational).
//   Store side: st_word_i/st_off_i/st_data_i -> st_be_o, st_wdata_o
//               (word: all lanes; byte: one lane, data replicated 4x).
//   Load side : ld_word_i/ld_off_i/ld_rdata_i -> ld_data_o
//               (word: passthrough; byte: selected lane zero-extended).
module mem_align
   import mem_pkg::*;
(
   input  logic        st_word_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_wdata_o,
   input  logic        ld_word_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   always_comb begin
      st_be_o    = BE_WORD;
      st_wdata_o = st_data_i;
      if (!st_word_i) begin
         unique case (st_off_i)
            2'd0: st_be_o = BE_B0;
            2'd1: st_be_o = BE_B1;
            2'd2: st_be_o = BE_B2;
            2'd3: st_be_o = BE_B3;
         endcase
         // Replicating the byte lets memory pick it up on whichever lane is enabled.
         st_wdata_o = {4{st_data_i[7:0]}};
      end
   end

   always_comb begin
      ld_data_o = ld_rdata_i;
      if (!ld_word_i) begin
         ld_data_o = '0;
         unique case (ld_off_i)
            2'd0: ld_data_o[7:0] = ld_rdata_i[7:0];
            2'd1: ld_data_o[7:0] = ld_rdata_i[15:8];
            2'd2: ld_data_o[7:0] = ld_rdata_i[23:16];
            2'd3: ld_data_o[7:0] = ld_rdata_i[31:24];
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: consumes EX/MEM fields, runs data-memory accesses over
// a req/ack handshake and drives the MEM/WB register.
//   EX/MEM in : memRead, memWrite, word, memToReg, regWrite, result, readData2, rd
//   Upstream  : stall (high while an access is outstanding)
//   Memory    : mem_req, mem_we, mem_addr, mem_be, mem_wdata / mem_ack, mem_rdata
//   MEM/WB out: wb_regWrite, wb_memToReg, wb_rd, wb_result, wb_readData
//   err       : one-cycle pulse on misaligned access or timeout abort
module mem_stage
   import mem_pkg::*;
#(
   parameter int MEM_AW  = 10,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              word,
   input  logic              memToReg,
   input  logic              regWrite,
   input  logic [31:0]       result,
   input  logic [31:0]       readData2,
   input  logic [4:0]        rd,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              wb_regWrite,
   output logic              wb_memToReg,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_result,
   output logic [31:0]       wb_readData,
   output logic              err
);

   // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
   localparam int CW = $clog2(TIMEOUT + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Holding registers for the access in flight.
   logic          we_q, we_d;
   logic          hword_q, hword_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [4:0]    hrd_q, hrd_d;
   logic          hm2r_q, hm2r_d;
   logic          hrw_q, hrw_d;
   logic [31:0]   hres_q, hres_d;

   // MEM/WB register.
   logic          wb_rw_q, wb_rw_d;
   logic          wb_m2r_q, wb_m2r_d;
   logic [4:0]    wb_rd_q, wb_rd_d;
   logic [31:0]   wb_res_q, wb_res_d;
   logic [31:0]   wb_rdata_q, wb_rdata_d;
   logic          err_q, err_d;

   logic [3:0]    st_be;
   logic [31:0]   st_wdata;
   logic [31:0]   ld_data;
   logic          access, misaligned;

   mem_align u_align (
      .st_word_i  (word),
      .st_off_i   (result[1:0]),
      .st_data_i  (readData2),
      .st_be_o    (st_be),
      .st_wdata_o (st_wdata),
      .ld_word_i  (hword_q),
      .ld_off_i   (hres_q[1:0]),
      .ld_rdata_i (mem_rdata),
      .ld_data_o  (ld_data)
   );

   assign access     = memRead | memWrite;
   assign misaligned = word & (result[1:0] != 2'b00);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      hword_d    = hword_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      hrd_d      = hrd_q;
      hm2r_d     = hm2r_q;
      hrw_d      = hrw_q;
      hres_d     = hres_q;
      wb_rw_d    = wb_rw_q;
      wb_m2r_d   = wb_m2r_q;
      wb_rd_d    = wb_rd_q;
      wb_res_d   = wb_res_q;
      wb_rdata_d = wb_rdata_q;
      err_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!access || misaligned) begin
               // Passthrough, or a killed access that retires without writeback.
               wb_rw_d    = regWrite & ~access;
               wb_m2r_d   = memToReg;
               wb_rd_d    = rd;
               wb_res_d   = result;
               wb_rdata_d = '0;
               err_d      = access;
            end else begin
               // memWrite wins when both request bits are set.
               we_d    = memWrite;
               hword_d = word;
               be_d    = st_be;
               wdata_d = st_wdata;
               hrd_d   = rd;
               hm2r_d  = memToReg;
               hrw_d   = regWrite;
               hres_d  = result;
               cnt_d   = '0;
               wb_rw_d = 1'b0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            wb_rw_d = 1'b0;
            if (mem_ack) begin
               // Ack has priority over a coincident timeout.
               wb_rw_d    = hrw_q;
               wb_m2r_d   = hm2r_q;
               wb_rd_d    = hrd_q;
               wb_res_d   = hres_q;
               wb_rdata_d = we_q ? 32'd0 : ld_data;
               state_d    = IDLE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         hword_q    <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         hrd_q      <= '0;
         hm2r_q     <= 1'b0;
         hrw_q      <= 1'b0;
         hres_q     <= '0;
         wb_rw_q    <= 1'b0;
         wb_m2r_q   <= 1'b0;
         wb_rd_q    <= '0;
         wb_res_q   <= '0;
         wb_rdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         hword_q    <= hword_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         hrd_q      <= hrd_d;
         hm2r_q     <= hm2r_d;
         hrw_q      <= hrw_d;
         hres_q     <= hres_d;
         wb_rw_q    <= wb_rw_d;
         wb_m2r_q   <= wb_m2r_d;
         wb_rd_q    <= wb_rd_d;
         wb_res_q   <= wb_res_d;
         wb_rdata_q <= wb_rdata_d;
         err_q      <= err_d;
      end
   end

   assign stall       = (state_q == BUSY);
   assign mem_req     = (state_q == BUSY);
   assign mem_we      = we_q;
   assign mem_addr    = hres_q[MEM_AW+1:2];
   assign mem_be      = be_q;
   assign mem_wdata   = wdata_q;
   assign wb_regWrite = wb_rw_q;
   assign wb_memToReg = wb_m2r_q;
   assign wb_rd       = wb_rd_q;
   assign wb_result   = wb_res_q;
   assign wb_readData = wb_rdata_q;
   assign err         = err_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam int AW = 10;
   localparam int TO = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          memRead, memWrite, word, memToReg, regWrite;
   logic [31:0]   result, readData2;
   logic [4:0]    rd;
   logic          stall, mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic          mem_ack;
   logic [31:0]   mem_rdata;
   logic          wb_regWrite, wb_memToReg;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_result, wb_readData;
   logic          err;

   always #5 clock = ~clock;

   mem_stage #(.MEM_AW(AW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .memRead(memRead), .memWrite(memWrite), .word(word),
      .memToReg(memToReg), .regWrite(regWrite),
      .result(result), .readData2(readData2), .rd(rd),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg), .wb_rd(wb_rd),
      .wb_result(wb_result), .wb_readData(wb_readData), .err(err)
   );

   typedef struct {
      logic        rw;
      logic        m2r;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [31:0] rdata;
      logic        err;
      logic        full;   // 0: only rw/err are defined (timeout abort)
   } exp_t;

   exp_t        sb[$];
   int          nvec = 0;
   int          nfail = 0;
   bit          mon_en = 1'b1;
   logic [31:0] model_mem [1024];
   logic [31:0] dut_mem   [1024];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every retire edge pops one expected MEM/WB record.
   initial begin
      bit   pv;
      logic s0, acc, mis;
      exp_t e;
      pv = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            sb.delete();
            pv = 1'b0;
         end else if (mon_en) begin
            if (pv) begin
               if ((!s0 && (!acc || mis)) || (s0 && !stall)) begin
                  if (!s0) chk("retire_stall", stall, 0);
                  if (sb.size() == 0) begin
                     nvec++;
                     nfail++;
                     $display("FAIL retire_unexpected: got a retire, expected none at %0t", $time);
                  end else begin
                     e = sb.pop_front();
                     chk("wb_regWrite", wb_regWrite, e.rw);
                     chk("err", err, e.err);
                     if (e.full) begin
                        chk("wb_memToReg", wb_memToReg, e.m2r);
                        chk("wb_rd", wb_rd, e.rd);
                        chk("wb_result", wb_result, e.res);
                        chk("wb_readData", wb_readData, e.rdata);
                     end
                  end
               end else begin
                  chk("bubble_regWrite", wb_regWrite, 0);
                  chk("bubble_err", err, 0);
                  chk("busy_stall", stall, 1);
                  chk("busy_req", mem_req, 1);
               end
            end
            s0  = stall;
            acc = memRead | memWrite;
            mis = word && (result[1:0] != 2'b00);
            pv  = 1'b1;
         end
      end
   end

   task automatic setmem(input int idx, input logic [31:0] v);
      model_mem[idx] = v;
      dut_mem[idx]   = v;
   endtask

   // Presents one instruction; returns 1 time unit after its retire edge.
   // ackd: BUSY cycle index in which ack is given (>= TO means never).
   task automatic run_instr(input logic rd_, input logic wr_, input logic wd,
                            input logic m2r, input logic rw, input logic [31:0] res,
                            input logic [31:0] d2, input logic [4:0] rdx,
                            input int ackd, input bit do_rst);
      exp_t        e;
      logic        acc, mis;
      logic [9:0]  idx;
      logic [1:0]  off;
      logic [31:0] w;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      memRead = rd_; memWrite = wr_; word = wd; memToReg = m2r; regWrite = rw;
      result = res; readData2 = d2; rd = rdx;
      mem_ack = 1'($urandom_range(0, 1));   // ignored outside BUSY
      mem_rdata = $urandom;
      acc = rd_ | wr_;
      mis = wd && (res[1:0] != 2'b00);
      idx = res[11:2];
      off = res[1:0];
      exp_be = wd ? 4'hF : 4'(1 << off);
      exp_wd = wd ? d2 : {4{d2[7:0]}};
      e.full = 1'b1; e.m2r = m2r; e.rd = rdx; e.res = res; e.rdata = 32'd0;
      if (!acc) begin
         e.rw = rw; e.err = 1'b0;
      end else if (mis) begin
         e.rw = 1'b0; e.err = 1'b1;
      end else if (ackd >= TO) begin
         e.rw = 1'b0; e.err = 1'b1; e.full = 1'b0;
      end else begin
         e.rw = rw; e.err = 1'b0;
         w = model_mem[idx];
         if (!wr_) begin
            e.rdata = wd ? w : ((w >> (8 * off)) & 32'hFF);
         end else begin
            if (wd) w = d2;
            else w[8*off +: 8] = d2[7:0];
            model_mem[idx] = w;
         end
      end
      if (!do_rst) sb.push_back(e);
      @(posedge clock); #1;
      mem_ack = 1'b0;
      if (acc && !mis) begin
         // EX/MEM must be ignored while busy: drive junk.
         memRead = 1'($urandom); memWrite = 1'($urandom); word = 1'($urandom);
         regWrite = 1'($urandom); memToReg = 1'($urandom);
         result = $urandom; readData2 = $urandom; rd = 5'($urandom);
         for (int i = 0; i < TO; i++) begin
            chk("mem_req_busy", mem_req, 1);
            if (i == 0) begin
               chk("mem_addr", 32'(mem_addr), 32'(idx));
               chk("mem_be", mem_be, exp_be);
               chk("mem_wdata", mem_wdata, exp_wd);
               chk("mem_we", mem_we, wr_);
            end
            if (do_rst && i == 1) begin
               #2 reset = 1'b1;
               memRead = 1'b0; memWrite = 1'b0;
               #1;
               chk("rst_mem_req", mem_req, 0);
               chk("rst_stall", stall, 0);
               chk("rst_wb_regWrite", wb_regWrite, 0);
               chk("rst_wb_memToReg", wb_memToReg, 0);
               chk("rst_wb_rd", wb_rd, 0);
               chk("rst_wb_result", wb_result, 0);
               chk("rst_wb_readData", wb_readData, 0);
               chk("rst_err", err, 0);
               chk("rst_mem_be", mem_be, 0);
               #3 reset = 1'b0;
               @(posedge clock); #1;
               return;
            end
            if (i == ackd) begin
               mem_ack = 1'b1;
               mem_rdata = dut_mem[mem_addr];
               if (mem_we) begin
                  w = dut_mem[mem_addr];
                  for (int b = 0; b < 4; b++)
                     if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                  dut_mem[mem_addr] = w;
               end
            end
            @(posedge clock); #1;
            mem_ack = 1'b0;
            if (i == ackd) break;
         end
         chk("mem_req_drop", mem_req, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic rdb, wrb, wdb;
      logic [31:0] r;
      reset = 1'b1;
      memRead = 0; memWrite = 0; word = 0; memToReg = 0; regWrite = 0;
      result = 0; readData2 = 0; rd = 0; mem_ack = 0; mem_rdata = 0;
      for (int i = 0; i < 1024; i++) setmem(i, $urandom);
      #2;
      chk("reset_stall", stall, 0);
      chk("reset_mem_req", mem_req, 0);
      chk("reset_mem_we", mem_we, 0);
      chk("reset_mem_addr", 32'(mem_addr), 0);
      chk("reset_mem_wdata", mem_wdata, 0);
      chk("reset_wb_regWrite", wb_regWrite, 0);
      chk("reset_wb_result", wb_result, 0);
      chk("reset_err", err, 0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;

      // Directed cases.
      run_instr(0, 0, 0, 0, 1, 32'h1234, 32'h0, 5'd5, 0, 0);        // ALU passthrough
      setmem(16, 32'hDEADBEEF);
      run_instr(1, 0, 1, 1, 1, 32'h40, 32'h0, 5'd3, 2, 0);          // word load, 3 BUSY cycles
      setmem(16, 32'h11223344);
      run_instr(0, 1, 0, 0, 0, 32'h43, 32'hAB, 5'd0, 0, 0);         // byte store lane 3
      run_instr(1, 0, 0, 1, 1, 32'h42, 32'h0, 5'd7, 0, 0);          // byte load lane 2
      run_instr(0, 1, 1, 0, 0, 32'h41, 32'h5555, 5'd1, 0, 0);       // misaligned word store
      run_instr(1, 0, 1, 1, 1, 32'h80, 32'h0, 5'd8, 99, 0);         // timeout
      run_instr(1, 0, 1, 1, 1, 32'h84, 32'h0, 5'd9, TO - 1, 0);     // ack on last cycle
      run_instr(1, 1, 0, 0, 1, 32'h45, 32'h77, 5'd2, 0, 0);         // both set -> store
      run_instr(1, 0, 1, 1, 1, 32'h88, 32'h0, 5'd10, 99, 1);        // reset mid-BUSY
      run_instr(0, 0, 0, 0, 1, 32'hCAFE, 32'h0, 5'd11, 0, 0);       // accepted after reset

      // Randomized traffic over a small address window so loads hit earlier stores.
      for (int n = 0; n < 300; n++) begin
         rdb = 1'($urandom_range(0, 9) < 4);
         wrb = 1'($urandom_range(0, 9) < 4);
         wdb = 1'($urandom);
         r = $urandom & 32'hFFFF_F03F;
         if (wdb && $urandom_range(0, 3) != 0) r[1:0] = 2'b00;
         run_instr(rdb, wrb, wdb, 1'($urandom), 1'($urandom), r, $urandom,
                   5'($urandom), $urandom_range(0, TO + 1), 0);
      end

      @(negedge clock); #1;
      mon_en = 1'b0;
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
